rr_arbiter4: RTL and testbench

//   Round-robin arbiter that shares one resource among four requesters.

---
 rtl/rr_arbiter4.sv | 103 ++++++++++
 tb/tb_rr_arbiter4.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters sharing one datapath unit.
// Registered one-hot grant with encoded index and hold-limit release.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNTW     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNTW-1:0] HOLD_LAST =
    CNTW'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);
  localparam bit HOLD_EN = (HOLD_MAX != 0);

  state_t          state, state_d;
  logic [1:0]      ptr, ptr_d;
  logic [CNTW-1:0] hold_cnt, hold_cnt_d;
  logic [3:0]      grant_d;
  logic [1:0]      grant_id_d;
  logic            timeout_d;
  logic [1:0]      sel;
  logic            found;

  // Scan requests starting at ptr, wrapping mod 4; first hit wins.
  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        sel   = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output values for IDLE/BUSY.
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    hold_cnt_d = hold_cnt;
    grant_d    = grant;
    grant_id_d = grant_id;
    timeout_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_d    = 4'b0001 << sel;
          grant_id_d = sel;
          hold_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (done || !req[grant_id]) begin
          grant_d = 4'b0000;
          ptr_d   = grant_id + 2'd1;
          state_d = IDLE;
        end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
          grant_d   = 4'b0000;
          ptr_d     = grant_id + 2'd1;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= '0;
      grant    <= 4'b0000;
      grant_id <= 2'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_cnt_d;
      grant    <= grant_d;
      grant_id <= grant_id_d;
      timeout  <= timeout_d;
    end
  end

  assign grant_valid = |grant;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed testbench for rr_arbiter4.
// Each task drives one scenario and checks outputs inline.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter4 #(
    .HOLD_MAX(8),
    .CNTW(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .grant(grant),
    .grant_id(grant_id),
    .grant_valid(grant_valid),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    tick();
    tick();
    n_checks++;
    if (grant !== 4'b0000) begin
      $display("FAIL reset_grant got=%b exp=0000", grant);
      n_fail++;
    end
    n_checks++;
    if (grant_id !== 2'd0) begin
      $display("FAIL reset_id got=%0d exp=0", grant_id);
      n_fail++;
    end
    n_checks++;
    if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL reset_flags got=%b%b exp=00", grant_valid, timeout);
      n_fail++;
    end
    req   = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    tick();
    n_checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2 || grant_valid !== 1'b1) begin
      $display("FAIL single_grant got=%b/%0d/%b exp=0100/2/1",
               grant, grant_id, grant_valid);
      n_fail++;
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL single_release got=%b/%b/%b exp=0000/0/0",
               grant, grant_valid, timeout);
      n_fail++;
    end
    n_checks++;
    if (grant_id !== 2'd2) begin
      $display("FAIL single_id_hold got=%0d exp=2", grant_id);
      n_fail++;
    end
    req = 4'b1001;
    tick();
    n_checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      $display("FAIL single_ptr3 got=%b/%0d exp=1000/3", grant, grant_id);
      n_fail++;
    end
    req = 4'b0000;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (grant !== 4'b0000) begin
      $display("FAIL idle_done got=%b exp=0000", grant);
      n_fail++;
    end
  endtask

  task automatic test_fairness();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (grant !== (4'b0001 << exp_id[k]) || grant_id !== 2'(exp_id[k])) begin
        $display("FAIL fair_grant%0d got=%b/%0d exp_id=%0d",
                 k, grant, grant_id, exp_id[k]);
        n_fail++;
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
        $display("FAIL fair_idle%0d got=%b/%b exp=0000/0",
                 k, grant, grant_valid);
        n_fail++;
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    req  = 4'b0010;
    done = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      $display("FAIL to_grant got=%b/%0d exp=0010/1", grant, grant_id);
      n_fail++;
    end
    for (int k = 1; k < 8; k++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0010 || timeout !== 1'b0) begin
        $display("FAIL to_hold%0d got=%b/%b exp=0010/0", k, grant, timeout);
        n_fail++;
      end
    end
    tick();
    n_checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1 || grant_valid !== 1'b0) begin
      $display("FAIL to_release got=%b/%b/%b exp=0000/1/0",
               grant, timeout, grant_valid);
      n_fail++;
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (timeout !== 1'b0) begin
      $display("FAIL to_pulse got=%b exp=0", timeout);
      n_fail++;
    end
  endtask

  task automatic test_req_drop();
    req = 4'b0100;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b1001;
    tick();
    n_checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      $display("FAIL drop_grant got=%b/%0d exp=1000/3", grant, grant_id);
      n_fail++;
    end
    req = 4'b0001;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      $display("FAIL drop_release got=%b/%b exp=0000/0", grant, timeout);
      n_fail++;
    end
    tick();
    n_checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      $display("FAIL drop_wrap got=%b/%0d exp=0001/0", grant, grant_id);
      n_fail++;
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    req = 4'b0010;
    tick();
    n_checks++;
    if (grant !== 4'b0010) begin
      $display("FAIL mrst_pre got=%b exp=0010", grant);
      n_fail++;
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      $display("FAIL mrst_drop got=%b/%b/%0d exp=0000/0/0",
               grant, grant_valid, grant_id);
      n_fail++;
    end
    req   = 4'b1010;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      $display("FAIL mrst_after got=%b/%0d exp=0010/1", grant, grant_id);
      n_fail++;
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_req_drop();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
